// File: rtl/msi_bus_arbiter.sv
// MSI coherence bus arbiter: round-robin grant of one request at a time. The granted op is
// broadcast as a snoop to the other caches. The fill word then comes from the lowest-index
// cache that reports found, or from main memory when no cache has it.
// Optional build macro: BUS_PERF_CNT_EN adds saturating counters perf_txn, perf_c2c and perf_stall.
module msi_bus_arbiter #(
    parameter int unsigned N_CORES = 2,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CORES-1:0]         req_valid,
    input  logic [2*N_CORES-1:0]       req_op,
    input  logic [ADDR_W*N_CORES-1:0]  req_addr,
    output logic [N_CORES-1:0]         grant,
    output logic                       snoop_valid,
    output logic [N_CORES-1:0]         snoop_en,
    output logic [1:0]                 bus_op,
    output logic [ADDR_W-1:0]          bus_addr,
    input  logic [N_CORES-1:0]         snoop_found,
    input  logic [DATA_W*N_CORES-1:0]  snoop_data,
    output logic                       mem_re,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_rdy,
    input  logic [DATA_W-1:0]          mem_rd_data,
    output logic [N_CORES-1:0]         resp_valid,
    output logic [DATA_W-1:0]          resp_data,
    output logic                       resp_from_c2c,
`ifdef BUS_PERF_CNT_EN
    output logic [15:0]                perf_txn,
    output logic [15:0]                perf_c2c,
    output logic [15:0]                perf_stall,
`endif
    output logic                       bus_busy
);

    localparam int unsigned IdxW   = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [1:0]  OpInval = 2'b11;

    typedef enum logic [1:0] {StIdle, StSnoop, StMem, StDone} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                c2c_q, c2c_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [N_CORES-1:0]  eligible;
    logic [N_CORES-1:0]  hi_mask;
    logic [N_CORES-1:0]  owner_mask;
    logic [N_CORES-1:0]  found;
    logic [N_CORES-1:0]  pick_mask;
    logic                pick_found;
    logic [IdxW-1:0]     pick_idx;
    logic [1:0]          pick_op;
    logic [ADDR_W-1:0]   pick_addr;
    logic [IdxW-1:0]     found_idx;
    logic [DATA_W-1:0]   found_data;

    function automatic logic [IdxW-1:0] lowest_idx(input logic [N_CORES-1:0] v);
        lowest_idx = '0;
        for (int k = int'(N_CORES) - 1; k >= 0; k--) begin
            if (v[k]) lowest_idx = IdxW'(k);
        end
    endfunction

    // Round-robin pick: first eligible core at/after rr_ptr, else first eligible overall
    always_comb begin
        eligible   = '0;
        hi_mask    = '0;
        owner_mask = '0;
        pick_mask  = '0;
        pick_op    = '0;
        pick_addr  = '0;
        for (int k = 0; k < N_CORES; k++) begin
            eligible[k]   = req_valid[k] && (req_op[2*k +: 2] != 2'b00);
            hi_mask[k]    = (IdxW'(k) >= rr_ptr_q);
            owner_mask[k] = (IdxW'(k) == owner_q);
        end
        pick_found = |eligible;
        pick_idx   = (|(eligible & hi_mask)) ? lowest_idx(eligible & hi_mask)
                                             : lowest_idx(eligible);
        for (int k = 0; k < N_CORES; k++) begin
            if (IdxW'(k) == pick_idx) begin
                pick_mask[k] = 1'b1;
                pick_op      = req_op[2*k +: 2];
                pick_addr    = req_addr[ADDR_W*k +: ADDR_W];
            end
        end
    end

    // Snoop hit selection: owner's own hit is ignored, lowest remaining index supplies data
    always_comb begin
        found      = snoop_found & ~owner_mask;
        found_idx  = lowest_idx(found);
        found_data = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (IdxW'(k) == found_idx) found_data = snoop_data[DATA_W*k +: DATA_W];
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        op_d          = op_q;
        addr_d        = addr_q;
        data_d        = data_q;
        c2c_d         = c2c_q;
        rr_ptr_d      = rr_ptr_q;
        grant         = '0;
        snoop_valid   = 1'b0;
        snoop_en      = '0;
        mem_re        = 1'b0;
        resp_valid    = '0;
        resp_data     = '0;
        resp_from_c2c = 1'b0;
        unique case (state_q)
            StIdle: begin
                // rst_n gate keeps grant low while reset is held with requests pending
                if (pick_found && rst_n) begin
                    grant   = pick_mask;
                    owner_d = pick_idx;
                    op_d    = pick_op;
                    addr_d  = pick_addr;
                    data_d  = '0;
                    c2c_d   = 1'b0;
                    state_d = StSnoop;
                end
            end
            StSnoop: begin
                snoop_valid = 1'b1;
                snoop_en    = ~owner_mask;
                if (op_q == OpInval) begin
                    data_d  = '0;
                    c2c_d   = 1'b0;
                    state_d = StDone;
                end else if (|found) begin
                    data_d  = found_data;
                    c2c_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StMem;
                end
            end
            StMem: begin
                mem_re = 1'b1;
                if (mem_rdy) begin
                    data_d  = mem_rd_data;
                    c2c_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                resp_valid    = owner_mask;
                resp_data     = data_q;
                resp_from_c2c = c2c_q;
                rr_ptr_d      = (owner_q == IdxW'(N_CORES - 1)) ? '0 : owner_q + IdxW'(1);
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and transaction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            op_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            c2c_q    <= 1'b0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            c2c_q    <= c2c_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus_busy = (state_q != StIdle);
    assign bus_op   = op_q;
    assign bus_addr = addr_q;
    assign mem_addr = addr_q;

`ifdef BUS_PERF_CNT_EN
    logic [15:0] txn_q, c2c_cnt_q, stall_q;
    logic        stall_evt;

    assign stall_evt = bus_busy && |(eligible & ~owner_mask);

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_q     <= '0;
            c2c_cnt_q <= '0;
            stall_q   <= '0;
        end else begin
            if (state_q == StDone && txn_q != 16'hFFFF) txn_q <= txn_q + 16'd1;
            if (state_q == StDone && c2c_q && c2c_cnt_q != 16'hFFFF) begin
                c2c_cnt_q <= c2c_cnt_q + 16'd1;
            end
            if (stall_evt && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
        end
    end

    assign perf_txn   = txn_q;
    assign perf_c2c   = c2c_cnt_q;
    assign perf_stall = stall_q;
`endif

endmodule
